// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port 16-bit memory between an instruction-fetch port (I)
//   and a load/store port (D). Only one transaction is in flight at a time.
//
//   Parameter
//     MEM_LAT   cycles from the MemEn pulse to valid MemRData (1..15)
//   Ports
//     Clock, ResetN                 single rising-edge clock, async active-low reset
//     IReq/IAddr -> IGnt            fetch request (always a read), combinational grant
//     IValid/IData                  fetch response pulse and held read data
//     DReq/DWe/DAddr/DWData -> DGnt load/store request, combinational grant
//     DValid/DRData                 read data / write ack pulse and held read data
//     MemEn/MemWe/MemAddr/MemWData  memory command (MemEn is a one-cycle pulse)
//     MemRData                      memory read data, sampled MEM_LAT cycles after MemEn
//     Busy                          high whenever the controller is not idle
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic        IReq,
    input  logic [15:0] IAddr,
    output logic        IGnt,
    output logic        IValid,
    output logic [15:0] IData,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [15:0] DAddr,
    input  logic [15:0] DWData,
    output logic        DGnt,
    output logic        DValid,
    output logic [15:0] DRData,
    output logic        MemEn,
    output logic        MemWe,
    output logic [15:0] MemAddr,
    output logic [15:0] MemWData,
    input  logic [15:0] MemRData,
    output logic        Busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_d_q, last_d_d;   // last grant went to D
    logic        own_d_q, own_d_d;     // current transaction belongs to D
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] idata_q, idata_d;
    logic [15:0] drdata_q, drdata_d;
    logic        ivalid_q, ivalid_d;
    logic        dvalid_q, dvalid_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic        busy_q, busy_d;
    logic        i_gnt, d_gnt;

    // Grants are gated by ResetN so they drop immediately while reset is held.
    // On a tie the port that was not granted last wins.
    always_comb begin
        i_gnt = ResetN && (state_q == StIdle) && IReq && (!DReq || last_d_q);
        d_gnt = ResetN && (state_q == StIdle) && DReq && (!IReq || !last_d_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d_d = last_d_q;
        own_d_d  = own_d_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        idata_d  = idata_q;
        drdata_d = drdata_q;
        ivalid_d = 1'b0;
        dvalid_d = 1'b0;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_gnt || d_gnt) begin
                    state_d  = StIssue;
                    last_d_d = d_gnt;
                    own_d_d  = d_gnt;
                    we_d     = d_gnt && DWe;
                    addr_d   = d_gnt ? DAddr : IAddr;
                    if (d_gnt) begin
                        wdata_d = DWData;
                    end
                    mem_en_d = 1'b1;
                    mem_we_d = d_gnt && DWe;
                end
            end
            StIssue: begin
                if (we_q) begin
                    // Writes complete at issue; acknowledge on the next cycle.
                    state_d  = StResp;
                    dvalid_d = 1'b1;
                end else begin
                    state_d = StWait;
                    cnt_d   = 4'(MEM_LAT - 1);
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    if (own_d_q) begin
                        drdata_d = MemRData;
                        dvalid_d = 1'b1;
                    end else begin
                        idata_d  = MemRData;
                        ivalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            last_d_q <= 1'b1;
            own_d_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            idata_q  <= 16'h0000;
            drdata_q <= 16'h0000;
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_d_q <= last_d_d;
            own_d_q  <= own_d_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            idata_q  <= idata_d;
            drdata_q <= drdata_d;
            ivalid_q <= ivalid_d;
            dvalid_q <= dvalid_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
            busy_q   <= busy_d;
        end
    end

    // MemAddr/MemWData are the latched request fields, so they hold outside issue.
    always_comb begin
        IGnt     = i_gnt;
        DGnt     = d_gnt;
        IValid   = ivalid_q;
        IData    = idata_q;
        DValid   = dvalid_q;
        DRData   = drdata_q;
        MemEn    = mem_en_q;
        MemWe    = mem_we_q;
        MemAddr  = addr_q;
        MemWData = wdata_q;
        Busy     = busy_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT = 1, 2, 15), each with a
// behavioural memory that drives valid MemRData only in the cycle MEM_LAT after
// MemEn. A transaction-level model predicts every output from the timeline
// rules (grant cycle + fixed offsets) and a reference memory array.
module tb_mem_port_arbiter;

    function automatic int unsigned lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 15);
    endfunction

    function automatic logic [15:0] init_word(input int g, input int i);
        if (g == 1 && i == 16) return 16'hABCD;
        return 16'(i * 40503 + g * 7919) ^ 16'h5A5A;
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        ireq [3];
    logic        dreq [3];
    logic        dwe [3];
    logic [15:0] iaddr [3];
    logic [15:0] daddr [3];
    logic [15:0] dwdata [3];
    logic [15:0] mrdata [3];
    logic        ignt [3];
    logic        dgnt [3];
    logic        ivalid [3];
    logic        dvalid [3];
    logic        memen [3];
    logic        memwe [3];
    logic        busy [3];
    logic [15:0] idata [3];
    logic [15:0] drdata [3];
    logic [15:0] maddr [3];
    logic [15:0] mwdata [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_arbiter #(.MEM_LAT(lat_of(g))) u_dut (
            .Clock   (clk),
            .ResetN  (rst_n),
            .IReq    (ireq[g]),
            .IAddr   (iaddr[g]),
            .IGnt    (ignt[g]),
            .IValid  (ivalid[g]),
            .IData   (idata[g]),
            .DReq    (dreq[g]),
            .DWe     (dwe[g]),
            .DAddr   (daddr[g]),
            .DWData  (dwdata[g]),
            .DGnt    (dgnt[g]),
            .DValid  (dvalid[g]),
            .DRData  (drdata[g]),
            .MemEn   (memen[g]),
            .MemWe   (memwe[g]),
            .MemAddr (maddr[g]),
            .MemWData(mwdata[g]),
            .MemRData(mrdata[g]),
            .Busy    (busy[g])
        );
    end

    // Behavioural memories: garbage on MemRData except in the data cycle.
    logic [15:0] mem_env [3][256];
    int          pend [3];
    logic [7:0]  raddr [3];

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!rst_n) begin
                pend[g]   = 0;
                mrdata[g] = 16'($urandom);
                for (int i = 0; i < 256; i++) mem_env[g][i] = init_word(g, i);
            end else begin
                if (pend[g] > 0) begin
                    pend[g]--;
                    mrdata[g] = (pend[g] == 0) ? mem_env[g][raddr[g]] : 16'($urandom);
                end else begin
                    mrdata[g] = 16'($urandom);
                end
                if (memen[g] && memwe[g]) begin
                    mem_env[g][maddr[g][7:0]] = mwdata[g];
                end else if (memen[g]) begin
                    pend[g]  = int'(lat_of(g));
                    raddr[g] = maddr[g][7:0];
                end
            end
        end
    end

    // Reference model state
    int          checks = 0;
    int          errors = 0;
    int          cur = 0;
    int          cyc_n = 0;
    int          idle_at, issue_at, valid_at;
    bit          own_d, own_we, last_d, hold;
    logic [15:0] e_addr, e_wdata, e_idata, e_drdata, pend_data;
    logic [15:0] ref_mem [256];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: cycle %0d lat %0d observed %h expected %h",
                   tag, cyc_n, lat_of(cur), obs, exp);
        end
    endtask

    task automatic model_reset();
        idle_at  = 0;
        issue_at = -1;
        valid_at = -1;
        own_d    = 1'b0;
        own_we   = 1'b0;
        last_d   = 1'b1;
        e_addr   = 16'h0;
        e_wdata  = 16'h0;
        e_idata  = 16'h0;
        e_drdata = 16'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(cur, i);
    endtask

    // One clock cycle: called right after a falling edge with inputs applied.
    task automatic cyc();
        int unsigned lat;
        bit idle, ig, dg;
        lat = lat_of(cur);
        #1;
        if (!rst_n) model_reset();
        idle = (cyc_n >= idle_at);
        ig = rst_n && idle && ireq[cur] && (!dreq[cur] || last_d);
        dg = rst_n && idle && dreq[cur] && (!ireq[cur] || !last_d);
        if (cyc_n == valid_at && !own_we) begin
            if (own_d) e_drdata = pend_data;
            else e_idata = pend_data;
        end
        chk("IGnt", 16'(ignt[cur]), 16'(ig));
        chk("DGnt", 16'(dgnt[cur]), 16'(dg));
        chk("Busy", 16'(busy[cur]), 16'(!idle));
        chk("MemEn", 16'(memen[cur]), 16'(cyc_n == issue_at));
        chk("MemWe", 16'(memwe[cur]), 16'(cyc_n == issue_at && own_we));
        chk("MemAddr", maddr[cur], e_addr);
        chk("IValid", 16'(ivalid[cur]), 16'(cyc_n == valid_at && !own_d));
        chk("DValid", 16'(dvalid[cur]), 16'(cyc_n == valid_at && own_d));
        chk("IData", idata[cur], e_idata);
        chk("DRData", drdata[cur], e_drdata);
        if (cyc_n == issue_at && own_we) chk("MemWData", mwdata[cur], e_wdata);
        if (ig || dg) begin
            own_d    = dg;
            own_we   = dg && dwe[cur];
            last_d   = dg;
            e_addr   = dg ? daddr[cur] : iaddr[cur];
            if (dg) e_wdata = dwdata[cur];
            issue_at = cyc_n + 1;
            valid_at = cyc_n + (own_we ? 2 : 2 + int'(lat));
            idle_at  = valid_at + 1;
            if (own_we) ref_mem[e_addr[7:0]] = e_wdata;
            else pend_data = ref_mem[e_addr[7:0]];
        end
        @(negedge clk);
        cyc_n++;
        if (!hold) begin
            if (ig) ireq[cur] = 1'b0;
            if (dg) dreq[cur] = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic phase_start(input int g);
        cur = g;
        #2 rst_n = 1'b0;
        @(negedge clk);
        cyc_n++;
        run(2);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            ireq[g] = 1'b0; dreq[g] = 1'b0; dwe[g] = 1'b0;
            iaddr[g] = 16'h0; daddr[g] = 16'h0; dwdata[g] = 16'h0;
        end
        hold = 1'b0;

        // Directed steps on the MEM_LAT = 2 instance
        phase_start(1);
        // Single fetch read of 0x0010 returning 0xABCD
        ireq[1] = 1'b1; iaddr[1] = 16'h0010;
        run(6);
        chk("read_IData_ABCD", idata[1], 16'hABCD);
        // Single write 0x1234 -> 0x0200, then read it back on D
        dreq[1] = 1'b1; dwe[1] = 1'b1; daddr[1] = 16'h0200; dwdata[1] = 16'h1234;
        run(4);
        dreq[1] = 1'b1; dwe[1] = 1'b0; daddr[1] = 16'h0200;
        run(7);
        chk("readback_DRData", drdata[1], 16'h1234);
        // Tie: both requests held; grants must alternate I, D, I, D
        hold = 1'b1;
        ireq[1] = 1'b1; iaddr[1] = 16'h0003;
        dreq[1] = 1'b1; dwe[1] = 1'b0; daddr[1] = 16'h0007;
        run(24);
        hold = 1'b0;
        ireq[1] = 1'b0; dreq[1] = 1'b0;
        run(6);
        // Late D request raised during the WAIT of an I read
        ireq[1] = 1'b1; iaddr[1] = 16'h0021;
        run(2);
        dreq[1] = 1'b1; dwe[1] = 1'b1; daddr[1] = 16'h0022; dwdata[1] = 16'hBEEF;
        run(10);
        // D request raised during RESP of an I read: granted the next cycle
        ireq[1] = 1'b1; iaddr[1] = 16'h0022;
        run(4);
        dreq[1] = 1'b1; dwe[1] = 1'b0; daddr[1] = 16'h0021;
        run(8);
        // Reset during WAIT with both requests pending
        ireq[1] = 1'b1; iaddr[1] = 16'h0005;
        run(2);
        dreq[1] = 1'b1; dwe[1] = 1'b0; daddr[1] = 16'h0006;
        ireq[1] = 1'b1; iaddr[1] = 16'h0008;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_IGnt", 16'(ignt[1]), 16'h0);
        chk("rst_DGnt", 16'(dgnt[1]), 16'h0);
        chk("rst_IValid", 16'(ivalid[1]), 16'h0);
        chk("rst_DValid", 16'(dvalid[1]), 16'h0);
        chk("rst_MemEn", 16'(memen[1]), 16'h0);
        chk("rst_MemWe", 16'(memwe[1]), 16'h0);
        chk("rst_Busy", 16'(busy[1]), 16'h0);
        chk("rst_IData", idata[1], 16'h0);
        chk("rst_DRData", drdata[1], 16'h0);
        chk("rst_MemAddr", maddr[1], 16'h0);
        chk("rst_MemWData", mwdata[1], 16'h0);
        @(negedge clk);
        cyc_n++;
        run(2);
        rst_n = 1'b1;
        #1;
        chk("post_rst_IGnt_first", 16'(ignt[1]), 16'h1);
        @(negedge clk);
        cyc_n++;
        // Re-run that cycle through the model from a fresh reset view
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        run(14);
        ireq[1] = 1'b0; dreq[1] = 1'b0;
        run(6);

        // Randomized traffic on every latency build
        for (int g = 0; g < 3; g++) begin
            phase_start(g);
            for (int n = 0; n < 300; n++) begin
                if (!ireq[g] && $urandom_range(0, 2) == 0) begin
                    ireq[g]  = 1'b1;
                    iaddr[g] = {8'($urandom), 4'h0, 4'($urandom)};
                end
                if (!dreq[g] && $urandom_range(0, 2) == 0) begin
                    dreq[g]   = 1'b1;
                    dwe[g]    = 1'($urandom);
                    daddr[g]  = {8'($urandom), 4'h0, 4'($urandom)};
                    dwdata[g] = 16'($urandom);
                end
                cyc();
            end
            ireq[g] = 1'b0; dreq[g] = 1'b0;
            run(20);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MEM_LAT, default 2, cycles from MemEn pulse to valid MemRData; legal range 1..15.
REQ-002 Ports: Clock  in  1  single clock, all state updates on rising edge.
REQ-003 Ports: ResetN  in  1  asynchronous, active-low reset.
REQ-004 Ports: IReq in 1 fetch request; IAddr in 16 fetch address; IGnt out 1 fetch grant; IValid out 1 fetch data valid; IData out 16 fetch data.
REQ-005 Ports: DReq in 1 data request; DWe in 1 write when 1; DAddr in 16; DWData in 16; DGnt out 1; DValid out 1 read data / write ack; DRData out 16.
REQ-006 Ports: MemEn out 1; MemWe out 1; MemAddr out 16; MemWData out 16; MemRData in 16; Busy out 1 (state != IDLE).

Function
REQ-007 Block SHALL share one single-port 16-bit memory between CPU fetch (I) and load/store (D), one transaction in flight at a time.
REQ-008 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-009 IGnt/DGnt SHALL be combinational, asserted only in IDLE, at most one per cycle; all other outputs registered.
REQ-010 Arbitration in IDLE: single requester -> granted; both -> the one not granted last (LastD flag, updated on every grant).
REQ-011 On grant edge: latch address, DWe, DWData, and owner; IDLE -> ISSUE.
REQ-012 ISSUE (exactly 1 cycle): MemEn=1, MemAddr=latched addr, MemWe=latched DWe (0 for I), MemWData=latched data.
REQ-013 ISSUE -> RESP for writes; ISSUE -> WAIT for reads.
REQ-014 WAIT SHALL last MEM_LAT cycles (4-bit down-counter loaded with MEM_LAT-1, leaves at 0); MemRData captured on edge ending last WAIT cycle, i.e. MemEn cycle + MEM_LAT.
REQ-015 RESP (exactly 1 cycle): owner's Valid=1; read data presented on IData/DRData; RESP -> IDLE.
REQ-016 Read timeline, grant cycle 0: MemEn cycle 1, data sampled in cycle 1+MEM_LAT, Valid cycle 2+MEM_LAT, next grant earliest cycle 3+MEM_LAT.
REQ-017 Write timeline: MemEn+MemWe cycle 1, DValid cycle 2, DRData unchanged, next grant earliest cycle 3.
REQ-018 IData/DRData SHALL hold last captured value until the next read by the same owner.
REQ-019 Outside ISSUE: MemEn=0, MemWe=0; MemAddr/MemWData hold last latched values.
REQ-020 Requests are level: requester holds Req (and addr/data) until its Gnt; Req sampled only in IDLE; Req changes outside IDLE ignored.
REQ-021 Requests arriving during RESP SHALL NOT be granted until the following IDLE cycle.
REQ-022 DWe ignored when DReq=0; IReq transactions are always reads.

Reset
REQ-023 ResetN=0 SHALL immediately force: state IDLE, counter 0, LastD=1 (first tie goes to I), IGnt=DGnt=IValid=DValid=MemEn=MemWe=Busy=0, IData=DRData=MemAddr=MemWData=0.
REQ-024 Reset mid-transaction SHALL discard it: no Valid pulse, no further MemEn; first grant after release at earliest on first rising edge with ResetN=1.

Verification
REQ-025 Read: after reset, IReq=1, IAddr=0x0010, memory returns 0xABCD at MEM_LAT=2 -> IGnt cycle 0, MemEn cycle 1 addr 0x0010, IValid cycle 4, IData=0xABCD.
REQ-026 Write: DReq=1, DWe=1, DAddr=0x0200, DWData=0x1234 -> DGnt cycle 0, MemEn=MemWe=1 cycle 1 with 0x0200/0x1234, DValid cycle 2, Busy low cycle 3.
REQ-027 Tie: IReq=DReq=1 held continuously -> grants alternate I, D, I, D; no cycle with both grants; Busy low exactly one cycle between transactions.
REQ-028 Late request: DReq raised during WAIT of an I read -> DGnt not before the IDLE following IValid; DReq raised during RESP -> granted next cycle.
REQ-029 Reset mid-operation: ResetN low during WAIT -> all outputs 0 asynchronously, no IValid ever issued; after release, IReq=DReq=1 -> IGnt first.
REQ-030 MEM_LAT=1 and MEM_LAT=15 builds: Valid exactly 2+MEM_LAT cycles after grant, data captured matches memory model.
